// File: rtl/ethernet_tx_framer_if.sv
// Payload byte stream into the transmit framer.
// Carries one byte per handshake; no internal storage.
// Consumer pulls with s_tready; producer holds data while s_tvalid && !s_tready.
interface ethernet_tx_framer_if;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tlast;
    logic       s_tready;

    modport master (
        output s_tdata,
        output s_tvalid,
        output s_tlast,
        input  s_tready
    );

    modport slave (
        input  s_tdata,
        input  s_tvalid,
        input  s_tlast,
        output s_tready
    );
endinterface

// File: rtl/ethernet_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble/SFD, header, payload, zero pad, CRC-32 FCS, IFG.
// Latency: s_tvalid in IDLE at t gives first preamble byte at t+1; payload accepted at t is on tx_data at t+1.
// Backpressure: s_tready only in PAYLOAD/DRAIN; a payload gap aborts the frame (underrun) and drains to tlast.
module ethernet_tx_framer #(
    parameter int MIN_PAYLOAD = 46,
    parameter int IFG_BYTES   = 12
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic [47:0]                cfg_dst_mac,
    input  logic [47:0]                cfg_src_mac,
    input  logic [15:0]                cfg_ethertype,
    ethernet_tx_framer_if.slave        s_axis,
    output logic [7:0]                 tx_data,
    output logic                       tx_en,
    output logic                       tx_busy,
    output logic                       frame_done,
    output logic                       underrun
);

    localparam int              CNT_W     = 16;
    localparam logic [10:0]     PAY_MAX   = 11'h7FF;
    localparam logic [10:0]     MIN_PAY_C = 11'(MIN_PAYLOAD);
    localparam logic [CNT_W-1:0] IFG_LAST = CNT_W'(IFG_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, DRAIN, IFG
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [10:0]       pay_q, pay_d, pay_inc;
    logic [31:0]       crc_q, crc_d;
    logic [111:0]      hdr_q, hdr_d;
    logic [7:0]        tx_data_d;
    logic              tx_en_d;
    logic              frame_done_d;
    logic              underrun_d;

    // Reflected CRC-32 advanced by one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    // Payload count including the byte being accepted; pinned at 2047 for jumbo streams.
    assign pay_inc = (pay_q == PAY_MAX) ? pay_q : pay_q + 11'd1;

    assign s_axis.s_tready = (state_q == PAYLOAD) || (state_q == DRAIN);
    assign tx_busy         = (state_q != IDLE);

    // State register.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; counters index bytes within the current state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (s_axis.s_tvalid) state_d = PREAMBLE;
            PREAMBLE: if (cnt_q == CNT_W'(6)) state_d = SFD;
            SFD:      state_d = HEADER;
            HEADER:   if (cnt_q == CNT_W'(13)) state_d = PAYLOAD;
            PAYLOAD: begin
                if (!s_axis.s_tvalid) begin
                    state_d = DRAIN;
                end else if (s_axis.s_tlast) begin
                    state_d = (pay_inc < MIN_PAY_C) ? PAD : FCS;
                end
            end
            PAD:      if (pay_inc >= MIN_PAY_C) state_d = FCS;
            FCS:      if (cnt_q == CNT_W'(3)) state_d = IFG;
            DRAIN:    if (s_axis.s_tvalid && s_axis.s_tlast) state_d = IFG;
            IFG:      if (cnt_q == IFG_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Next values for the output register and datapath; the IDLE exit already emits preamble byte 0.
    always_comb begin
        tx_data_d    = 8'h00;
        tx_en_d      = 1'b0;
        frame_done_d = 1'b0;
        underrun_d   = 1'b0;
        crc_d        = crc_q;
        hdr_d        = hdr_q;
        pay_d        = pay_q;
        cnt_d        = (state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
        case (state_q)
            IDLE: begin
                if (s_axis.s_tvalid) begin
                    tx_data_d = 8'h55;
                    tx_en_d   = 1'b1;
                    hdr_d     = {cfg_dst_mac, cfg_src_mac, cfg_ethertype};
                    crc_d     = 32'hFFFF_FFFF;
                    pay_d     = '0;
                    cnt_d     = CNT_W'(1);
                end
            end
            PREAMBLE: begin
                tx_data_d = 8'h55;
                tx_en_d   = 1'b1;
            end
            SFD: begin
                tx_data_d = 8'hD5;
                tx_en_d   = 1'b1;
            end
            HEADER: begin
                tx_data_d = hdr_q[111:104];
                tx_en_d   = 1'b1;
                hdr_d     = {hdr_q[103:0], 8'h00};
                crc_d     = crc32_byte(crc_q, hdr_q[111:104]);
            end
            PAYLOAD: begin
                if (s_axis.s_tvalid) begin
                    tx_data_d = s_axis.s_tdata;
                    tx_en_d   = 1'b1;
                    crc_d     = crc32_byte(crc_q, s_axis.s_tdata);
                    pay_d     = pay_inc;
                end else begin
                    underrun_d = 1'b1;
                end
            end
            PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc32_byte(crc_q, 8'h00);
                pay_d   = pay_inc;
            end
            FCS: begin
                // CRC register shifts down so the next FCS byte is always in bits [7:0].
                tx_data_d    = ~crc_q[7:0];
                tx_en_d      = 1'b1;
                crc_d        = {8'h00, crc_q[31:8]};
                frame_done_d = (cnt_q == CNT_W'(3));
            end
            default: begin
            end
        endcase
    end

    // Output register and datapath state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            tx_data    <= 8'h00;
            tx_en      <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            crc_q      <= 32'hFFFF_FFFF;
            hdr_q      <= '0;
            pay_q      <= '0;
            cnt_q      <= '0;
        end else begin
            tx_data    <= tx_data_d;
            tx_en      <= tx_en_d;
            frame_done <= frame_done_d;
            underrun   <= underrun_d;
            crc_q      <= crc_d;
            hdr_q      <= hdr_d;
            pay_q      <= pay_d;
            cnt_q      <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ethernet_tx_framer.sv
// Directed bench for ethernet_tx_framer: reset, min frame, padding, back-to-back, underrun, long frame, mid-frame reset.
module tb_ethernet_tx_framer;
    typedef logic [7:0] bq_t[$];

    logic        tb_ACLK = 1'b0;
    logic        ARESET;
    logic [47:0] cfg_dst_mac;
    logic [47:0] cfg_src_mac;
    logic [15:0] cfg_ethertype;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_busy;
    logic        frame_done;
    logic        underrun;

    int total = 0;
    int bad   = 0;

    logic [7:0] cap[$];
    int         capc[$];
    int         cyc    = 0;
    int         fd_cnt = 0;
    int         ur_cnt = 0;

    always #5 tb_ACLK = ~tb_ACLK;

    ethernet_tx_framer_if s_if();

    ethernet_tx_framer #(.MIN_PAYLOAD(46), .IFG_BYTES(12)) dut (
        .ACLK          (tb_ACLK),
        .ARESET        (ARESET),
        .cfg_dst_mac   (cfg_dst_mac),
        .cfg_src_mac   (cfg_src_mac),
        .cfg_ethertype (cfg_ethertype),
        .s_axis        (s_if),
        .tx_data       (tx_data),
        .tx_en         (tx_en),
        .tx_busy       (tx_busy),
        .frame_done    (frame_done),
        .underrun      (underrun)
    );

    // Wire monitor: every tx_en byte with its cycle number, plus pulse counts.
    always @(negedge tb_ACLK) begin
        cyc = cyc + 1;
        if (tx_en === 1'b1) begin
            cap.push_back(tx_data);
            capc.push_back(cyc);
        end
        if (frame_done === 1'b1) fd_cnt = fd_cnt + 1;
        if (underrun === 1'b1) ur_cnt = ur_cnt + 1;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    function automatic bq_t build_exp(input bq_t pl, input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
        bq_t q;
        bq_t body;
        logic [31:0] c;
        logic [111:0] h;
        h = {d, s, t};
        for (int i = 0; i < 7; i++) q.push_back(8'h55);
        q.push_back(8'hD5);
        for (int i = 0; i < 14; i++) body.push_back(h[111-8*i -: 8]);
        foreach (pl[i]) body.push_back(pl[i]);
        while (body.size() < 60) body.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        foreach (body[i]) c = crc_upd(c, body[i]);
        c = ~c;
        foreach (body[i]) q.push_back(body[i]);
        for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
        return q;
    endfunction

    function automatic bq_t grab(input int base, input int n);
        bq_t q;
        for (int i = 0; i < n; i++) if (base + i < cap.size()) q.push_back(cap[base + i]);
        return q;
    endfunction

    // Index of first differing byte (or shorter length), -1 when equal.
    function automatic int first_diff(input bq_t a, input bq_t b);
        int m;
        m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) if (a[i] !== b[i]) return i;
        if (a.size() != b.size()) return m;
        return -1;
    endfunction

    task automatic send_frame(input bq_t pl, input int gap_after, input bit keep_valid);
        for (int i = 0; i < pl.size(); i++) begin
            bit acc;
            int n;
            s_if.s_tdata  = pl[i];
            s_if.s_tlast  = (i == pl.size() - 1);
            s_if.s_tvalid = 1'b1;
            acc = 1'b0;
            n = 0;
            while (!acc && n < 300) begin
                @(negedge tb_ACLK);
                acc = (s_if.s_tready === 1'b1);
                @(posedge tb_ACLK);
                #1;
                n++;
            end
            if (!acc) begin
                total++;
                bad++;
                $display("FAIL accept_byte_%0d: s_tready low for %0d cycles, required 1", i, n);
                s_if.s_tvalid = 1'b0;
                s_if.s_tlast  = 1'b0;
                return;
            end
            if (i == gap_after) begin
                s_if.s_tvalid = 1'b0;
                @(posedge tb_ACLK);
                #1;
            end
        end
        if (!keep_valid) begin
            s_if.s_tvalid = 1'b0;
            s_if.s_tlast  = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge tb_ACLK);
        while (tx_busy !== 1'b0 && n < 4000) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (tx_busy !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: tx_busy=%b after %0d cycles, required 0", tx_busy, n);
        end
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge tb_ACLK);
        total++; if (tx_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en: got %b want 0", tx_en); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
        total++; if (tx_busy !== 1'b0) begin bad++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
        total++; if (s_if.s_tready !== 1'b0) begin bad++; $display("FAIL reset_tready: got %b want 0", s_if.s_tready); end
        total++; if (frame_done !== 1'b0 || underrun !== 1'b0) begin
            bad++; $display("FAIL reset_pulses: frame_done=%b underrun=%b want 0 0", frame_done, underrun);
        end
        @(posedge tb_ACLK);
        #1;
    endtask

    task automatic test_min_frame();
        bq_t pl, exp, got;
        int base, fd0, ur0, n, span, idx;
        logic [31:0] r;
        for (int i = 0; i < 46; i++) pl.push_back(8'(i));
        cfg_dst_mac = 48'hFFFF_FFFF_FFFF;
        cfg_src_mac = 48'h000A_3501_0203;
        cfg_ethertype = 16'h0800;
        exp = build_exp(pl, cfg_dst_mac, cfg_src_mac, cfg_ethertype);
        base = cap.size(); fd0 = fd_cnt; ur0 = ur_cnt;
        send_frame(pl, -1, 1'b0);
        wait_idle();
        n = cap.size() - base;
        got = grab(base, n);
        total++; if (n !== 72) begin bad++; $display("FAIL min_len: got %0d tx_en cycles want 72", n); end
        span = (n > 0) ? capc[base + n - 1] - capc[base] + 1 : 0;
        total++; if (span !== n) begin bad++; $display("FAIL min_contig: span %0d want %0d", span, n); end
        idx = -1;
        for (int i = 0; i < 8 && i < n; i++) if (got[i] !== ((i < 7) ? 8'h55 : 8'hD5)) begin idx = i; break; end
        total++; if (idx != -1 || n < 8) begin bad++; $display("FAIL min_preamble: byte %0d wrong (len %0d)", idx, n); end
        r = 32'hFFFF_FFFF;
        for (int i = 8; i < n; i++) r = crc_upd(r, got[i]);
        total++; if (r !== 32'hDEBB20E3) begin bad++; $display("FAIL min_residue: got %h want DEBB20E3", r); end
        idx = first_diff(got, exp);
        total++; if (idx != -1) begin bad++; $display("FAIL min_bytes: first diff at %0d", idx); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL min_frame_done: got %0d pulses want 1", fd_cnt - fd0); end
        total++; if (ur_cnt - ur0 !== 0) begin bad++; $display("FAIL min_underrun: got %0d pulses want 0", ur_cnt - ur0); end
    endtask

    task automatic test_pad();
        bq_t pl, exp, got;
        int base, fd0, n, idx, pad_bad;
        pl.push_back(8'hAB);
        exp = build_exp(pl, cfg_dst_mac, cfg_src_mac, cfg_ethertype);
        base = cap.size(); fd0 = fd_cnt;
        send_frame(pl, -1, 1'b0);
        wait_idle();
        n = cap.size() - base;
        got = grab(base, n);
        total++; if (n !== 72) begin bad++; $display("FAIL pad_len: got %0d want 72", n); end
        total++; if (n < 23 || got[22] !== 8'hAB) begin bad++; $display("FAIL pad_payload: byte 22 wrong, len %0d", n); end
        pad_bad = 0;
        for (int i = 23; i < 68; i++) if (i >= n || got[i] !== 8'h00) pad_bad++;
        total++; if (pad_bad != 0) begin bad++; $display("FAIL pad_zero: %0d non-zero pad bytes want 0", pad_bad); end
        idx = first_diff(got, exp);
        total++; if (idx != -1) begin bad++; $display("FAIL pad_fcs: first diff at %0d", idx); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL pad_frame_done: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_back_to_back();
        bq_t p1, p2, e1, e2, got;
        int base, fd0, n, idx, gap;
        for (int i = 0; i < 60; i++) begin
            p1.push_back(8'(8'hA0 + i));
            p2.push_back(8'(8'h10 + 3 * i));
        end
        cfg_dst_mac = 48'h0200_0000_0001;
        e1 = build_exp(p1, 48'h0200_0000_0001, cfg_src_mac, cfg_ethertype);
        e2 = build_exp(p2, 48'h0200_0000_0002, cfg_src_mac, cfg_ethertype);
        base = cap.size(); fd0 = fd_cnt;
        fork
            begin
                repeat (5) @(posedge tb_ACLK);
                #1;
                cfg_dst_mac = 48'h0200_0000_0002;
            end
        join_none
        send_frame(p1, -1, 1'b1);
        send_frame(p2, -1, 1'b0);
        wait_idle();
        n = cap.size() - base;
        total++; if (n !== 172) begin bad++; $display("FAIL b2b_len: got %0d want 172", n); end
        got = grab(base, 86);
        idx = first_diff(got, e1);
        total++; if (idx != -1) begin bad++; $display("FAIL b2b_frame1: first diff at %0d", idx); end
        got = grab(base + 86, 86);
        idx = first_diff(got, e2);
        total++; if (idx != -1) begin bad++; $display("FAIL b2b_frame2: first diff at %0d", idx); end
        gap = (n >= 87) ? capc[base + 86] - capc[base + 85] - 1 : -1;
        total++; if (gap !== 12) begin bad++; $display("FAIL b2b_ifg: got %0d idle cycles want 12", gap); end
        total++; if (fd_cnt - fd0 !== 2) begin bad++; $display("FAIL b2b_frame_done: got %0d want 2", fd_cnt - fd0); end
    endtask

    task automatic test_underrun();
        bq_t pl, exp, got;
        int base, fd0, ur0, n, idx, ifg;
        for (int i = 0; i < 20; i++) pl.push_back(8'(8'h30 + i));
        exp = build_exp(pl, cfg_dst_mac, cfg_src_mac, cfg_ethertype);
        base = cap.size(); fd0 = fd_cnt; ur0 = ur_cnt;
        send_frame(pl, 10, 1'b0);
        ifg = 0;
        @(negedge tb_ACLK);
        while (tx_busy === 1'b1 && ifg < 100) begin
            ifg++;
            @(negedge tb_ACLK);
        end
        @(posedge tb_ACLK);
        #1;
        n = cap.size() - base;
        got = grab(base, n);
        total++; if (n !== 33) begin bad++; $display("FAIL ur_len: got %0d tx_en cycles want 33", n); end
        while (exp.size() > 33) void'(exp.pop_back());
        idx = first_diff(got, exp);
        total++; if (idx != -1) begin bad++; $display("FAIL ur_bytes: first diff at %0d", idx); end
        total++; if (ur_cnt - ur0 !== 1) begin bad++; $display("FAIL ur_pulse: got %0d want 1", ur_cnt - ur0); end
        total++; if (fd_cnt - fd0 !== 0) begin bad++; $display("FAIL ur_frame_done: got %0d want 0", fd_cnt - fd0); end
        total++; if (ifg !== 12) begin bad++; $display("FAIL ur_ifg: got %0d busy cycles after tlast want 12", ifg); end
    endtask

    task automatic test_long();
        bq_t pl, exp, got;
        int base, fd0, n, idx, span;
        for (int i = 0; i < 1500; i++) pl.push_back(8'(i * 7 + 3));
        exp = build_exp(pl, cfg_dst_mac, cfg_src_mac, cfg_ethertype);
        repeat ($urandom_range(0, 7)) @(posedge tb_ACLK);
        #1;
        base = cap.size(); fd0 = fd_cnt;
        send_frame(pl, -1, 1'b0);
        wait_idle();
        n = cap.size() - base;
        got = grab(base, n);
        total++; if (n !== 1526) begin bad++; $display("FAIL long_len: got %0d want 1526", n); end
        span = (n > 0) ? capc[base + n - 1] - capc[base] + 1 : 0;
        total++; if (span !== n) begin bad++; $display("FAIL long_contig: span %0d want %0d", span, n); end
        idx = first_diff(got, exp);
        total++; if (idx != -1) begin bad++; $display("FAIL long_bytes: first diff at %0d", idx); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL long_frame_done: got %0d want 1", fd_cnt - fd0); end
    endtask

    task automatic test_reset_mid_frame();
        bq_t pl, exp, got;
        int base, fd0, n, idx;
        s_if.s_tdata  = 8'h11;
        s_if.s_tlast  = 1'b0;
        s_if.s_tvalid = 1'b1;
        repeat (12) @(posedge tb_ACLK);
        #1;
        total++; if (tx_en !== 1'b1) begin bad++; $display("FAIL rst_mid_active: tx_en %b want 1 in header", tx_en); end
        ARESET = 1'b1;
        s_if.s_tvalid = 1'b0;
        @(posedge tb_ACLK);
        #1;
        ARESET = 1'b0;
        @(negedge tb_ACLK);
        total++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin
            bad++; $display("FAIL rst_mid_tx: tx_en=%b tx_data=%h want 0 00", tx_en, tx_data);
        end
        total++; if (tx_busy !== 1'b0 || s_if.s_tready !== 1'b0) begin
            bad++; $display("FAIL rst_mid_busy: tx_busy=%b s_tready=%b want 0 0", tx_busy, s_if.s_tready);
        end
        total++; if (frame_done !== 1'b0 || underrun !== 1'b0) begin
            bad++; $display("FAIL rst_mid_pulses: frame_done=%b underrun=%b want 0 0", frame_done, underrun);
        end
        @(posedge tb_ACLK);
        #1;
        for (int i = 0; i < 10; i++) pl.push_back(8'(8'hC0 + i));
        exp = build_exp(pl, cfg_dst_mac, cfg_src_mac, cfg_ethertype);
        base = cap.size(); fd0 = fd_cnt;
        send_frame(pl, -1, 1'b0);
        wait_idle();
        n = cap.size() - base;
        got = grab(base, n);
        idx = first_diff(got, exp);
        total++; if (idx != -1) begin bad++; $display("FAIL rst_clean_bytes: first diff at %0d, len %0d want 72", idx, n); end
        total++; if (fd_cnt - fd0 !== 1) begin bad++; $display("FAIL rst_clean_done: got %0d want 1", fd_cnt - fd0); end
    endtask

    initial begin
        ARESET        = 1'b1;
        s_if.s_tdata  = 8'h00;
        s_if.s_tvalid = 1'b0;
        s_if.s_tlast  = 1'b0;
        cfg_dst_mac   = 48'hFFFF_FFFF_FFFF;
        cfg_src_mac   = 48'h000A_3501_0203;
        cfg_ethertype = 16'h0800;
        test_reset();
        test_min_frame();
        test_pad();
        test_back_to_back();
        test_underrun();
        test_long();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
